sdram_pattern_checker: RTL and testbench

Sequencer that drives the request side of `sdram_ctrl` in the SDRAM test design. It writes a deterministic pattern over a configurable word range, reads the range back, and compares each read word against the expected value. It reports pass/fail, an error count, the first failing address, and an LED code. It replaces the single-word write/read test logic at top level, sitting directly upstream of `sdram_ctrl`.

---
 rtl/sdram_pattern_checker.sv | 196 +++++++++++++++++++
 tb/tb_sdram_pattern_checker.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pattern_checker.sv
// Write/read-back pattern sequencer for the request side of sdram_ctrl.
// Writes SEED^i to words 0..NUM_WORDS-1, reads them back, and reports errors and status.
module sdram_pattern_checker #(
  parameter int          ADDR_WIDTH = 24,
  parameter int          DATA_WIDTH = 16,
  parameter int          NUM_WORDS  = 256,
  parameter logic [15:0] SEED       = 16'hF055,
  parameter int          INIT_WAIT  = 25000,
  parameter int          TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  output logic [ADDR_WIDTH-1:0] sdram_addr,
  output logic                  sdram_rh_wl,
  output logic [DATA_WIDTH-1:0] sdram_data_w,
  input  logic [DATA_WIDTH-1:0] sdram_data_r,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [7:0]            led
);

  localparam int          INIT_W   = $clog2(INIT_WAIT + 1);
  localparam int          TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);
  localparam logic [7:0]  LED_PASS = 8'h55;
  localparam logic [7:0]  LED_FAIL = 8'hAA;
  localparam logic [7:0]  LED_BUSY = 8'h0F;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           idx_q, idx_d;
  logic [INIT_W-1:0]     init_cnt_q, init_cnt_d;
  logic [TMO_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  req_q, req_d;
  logic                  rh_wl_q, rh_wl_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_w_q, data_w_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;
  logic [7:0]            led_q, led_d;

  function automatic logic [DATA_WIDTH-1:0] expected(input logic [15:0] i);
    logic [15:0] v;
    v = SEED ^ i;
    return DATA_WIDTH'(v);
  endfunction

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    req_d      = 1'b0;
    rh_wl_d    = rh_wl_q;
    addr_d     = addr_q;
    data_w_d   = data_w_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    err_cnt_d  = err_cnt_q;
    first_d    = first_q;

    unique case (state_q)
      S_INIT: begin
        if (init_cnt_q == INIT_W'(INIT_WAIT - 1)) state_d = S_IDLE;
        else init_cnt_d = init_cnt_q + INIT_W'(1);
      end
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_WR_REQ;
          idx_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          err_cnt_d = '0;
          first_d   = '0;
        end
      end
      S_WR_REQ: begin
        state_d    = S_WR_WAIT;
        wait_cnt_d = TMO_W'(1);
      end
      S_RD_REQ: begin
        state_d    = S_RD_WAIT;
        wait_cnt_d = TMO_W'(1);
      end
      S_WR_WAIT, S_RD_WAIT: begin
        if (sdram_ack) begin
          if (state_q == S_RD_WAIT && sdram_data_r != expected(idx_q)) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (err_cnt_q == 16'd0) first_d = ADDR_WIDTH'(idx_q);
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (state_q == S_WR_WAIT) ? S_RD_REQ : S_DONE;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = (state_q == S_WR_WAIT) ? S_WR_REQ : S_RD_REQ;
          end
        end else if (wait_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          // wait_cnt counts cycles since the request, so DONE lands TIMEOUT cycles after req
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + TMO_W'(1);
        end
      end
      default: state_d = S_INIT;
    endcase

    // Outputs are registered but derived from the next state, so they line up with it.
    if (state_d == S_WR_REQ) begin
      req_d    = 1'b1;
      rh_wl_d  = 1'b0;
      addr_d   = ADDR_WIDTH'(idx_d);
      data_w_d = expected(idx_d);
    end
    if (state_d == S_RD_REQ) begin
      req_d   = 1'b1;
      rh_wl_d = 1'b1;
      addr_d  = ADDR_WIDTH'(idx_d);
    end
    if (state_d == S_DONE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      pass_d = (err_cnt_d == 16'd0) && !timeout_d;
    end
    led_d = done_d ? (pass_d ? LED_PASS : LED_FAIL) : (busy_d ? LED_BUSY : 8'h00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      idx_q      <= '0;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      req_q      <= 1'b0;
      rh_wl_q    <= 1'b1;
      addr_q     <= '0;
      data_w_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_cnt_q  <= '0;
      first_q    <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      req_q      <= req_d;
      rh_wl_q    <= rh_wl_d;
      addr_q     <= addr_d;
      data_w_q   <= data_w_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      err_cnt_q  <= err_cnt_d;
      first_q    <= first_d;
      led_q      <= led_d;
    end
  end

  assign sdram_req      = req_q;
  assign sdram_rh_wl    = rh_wl_q;
  assign sdram_addr     = addr_q;
  assign sdram_data_w   = data_w_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_q;
  assign led            = led_q;

endmodule

// File: tb/tb_sdram_pattern_checker.sv
// Bench for sdram_pattern_checker: randomized SDRAM responder, transaction-level model
// of the expected sequencer behaviour, and a per-cycle compare against that model.
module tb_sdram_pattern_checker;

  localparam int          NW  = 4;
  localparam int          IW  = 8;
  localparam int          TMO = 15;
  localparam int          AW  = 24;
  localparam int          DW  = 16;
  localparam logic [15:0] SD  = 16'hF055;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          sdram_req;
  logic          sdram_ack = 1'b0;
  logic [AW-1:0] sdram_addr;
  logic          sdram_rh_wl;
  logic [DW-1:0] sdram_data_w;
  logic [DW-1:0] sdram_data_r = '0;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err_addr;
  logic [7:0]    led;

  sdram_pattern_checker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .SEED(SD),
    .INIT_WAIT(IW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_addr(sdram_addr),
    .sdram_rh_wl(sdram_rh_wl), .sdram_data_w(sdram_data_w), .sdram_data_r(sdram_data_r),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr), .led(led)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  initial forever @(posedge clk) cyc++;

  // ---------------- behavioural model ----------------
  int          mcyc = 0;
  int          m_init_edges, m_op, m_req_at;
  bit          m_ready, m_running, m_req, m_waiting, m_done, m_pass, m_timeout, m_fresh;
  logic [15:0] m_err;
  logic [AW-1:0] m_first;

  task automatic model_reset();
    m_ready = 0; m_init_edges = 0; m_running = 0; m_req = 0; m_waiting = 0;
    m_done = 0; m_pass = 0; m_timeout = 0; m_err = '0; m_first = '0; m_op = 0;
    m_fresh = 1;
  endtask

  task automatic model_finish();
    m_running = 0; m_waiting = 0; m_done = 1;
    m_pass = (m_err == 16'd0) && !m_timeout;
  endtask

  task automatic model_step();
    int w;
    mcyc++;
    if (!m_ready) begin
      m_init_edges++;
      if (m_init_edges == IW) m_ready = 1;
      return;
    end
    if (!m_running) begin
      if (start) begin
        m_running = 1; m_done = 0; m_pass = 0; m_timeout = 0; m_err = '0; m_first = '0;
        m_op = 0; m_req = 1; m_req_at = mcyc; m_waiting = 0; m_fresh = 0;
      end
      return;
    end
    if (m_req) begin
      m_req = 0; m_waiting = 1;
      return;
    end
    if (m_waiting) begin
      if (sdram_ack) begin
        if (m_op >= NW) begin
          w = m_op - NW;
          if (sdram_data_r !== (SD ^ 16'(w))) begin
            if (m_err == 16'd0) m_first = AW'(w);
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
          end
        end
        m_waiting = 0;
        m_op++;
        if (m_op == 2 * NW) model_finish();
        else begin m_req = 1; m_req_at = mcyc; end
      end else if ((mcyc - 1) - m_req_at == TMO - 1) begin
        m_timeout = 1;
        model_finish();
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic compare();
    logic [7:0] exp_led;
    if (reset) begin
      check("rst_req", sdram_req, 0);       check("rst_rh_wl", sdram_rh_wl, 1);
      check("rst_addr", sdram_addr, 0);     check("rst_data_w", sdram_data_w, 0);
      check("rst_busy", busy, 0);           check("rst_done", done, 0);
      check("rst_pass", pass, 0);           check("rst_timeout", timeout, 0);
      check("rst_err_cnt", err_cnt, 0);     check("rst_first", first_err_addr, 0);
      check("rst_led", led, 0);
      return;
    end
    exp_led = m_done ? (m_pass ? 8'h55 : 8'hAA) : (m_running ? 8'h0F : 8'h00);
    check("cyc_req", sdram_req, m_req);
    check("cyc_busy", busy, m_running);
    check("cyc_done", done, m_done);
    check("cyc_err_cnt", err_cnt, m_err);
    check("cyc_first", first_err_addr, m_first);
    check("cyc_timeout", timeout, m_timeout);
    check("cyc_led", led, exp_led);
    if (m_done) check("cyc_pass", pass, m_pass);
    if (m_req || m_waiting) begin
      check("cyc_addr", sdram_addr, AW'(m_op % NW));
      check("cyc_rh_wl", sdram_rh_wl, m_op >= NW);
      if (m_op < NW) check("cyc_data_w", sdram_data_w, SD ^ 16'(m_op));
    end
    if (m_fresh) begin
      check("idle_rh_wl", sdram_rh_wl, 1);
      check("idle_addr", sdram_addr, 0);
      check("idle_data_w", sdram_data_w, 0);
    end
  endtask

  initial forever @(negedge clk) compare();

  // ---------------- SDRAM responder ----------------
  logic [15:0]   mem [NW];
  logic [15:0]   wr_log [8];
  int            req_cyc_log [16];
  bit            pend = 0;
  int            cnt, req_num = 0, drop_idx = -1, corrupt_addr = -1, corrupt_pct = 0;
  int            dmin = 3, dmax = 3;
  bit            spur_en = 0, stray_en = 0;
  logic [AW-1:0] p_addr;
  bit            p_rd;
  logic [15:0]   p_data;

  initial begin : responder
    logic [15:0] v;
    int a;
    forever begin
      @(negedge clk);
      sdram_ack    = 1'b0;
      sdram_data_r = 16'($urandom);
      if (reset) begin
        pend = 0;
        continue;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 0;
          sdram_ack = 1'b1;
          a = int'(p_addr[15:0]) % NW;
          if (!p_rd) mem[a] = p_data;
          else begin
            v = mem[a];
            if (a == corrupt_addr) v = 16'h0000;
            else if ($urandom_range(99) < corrupt_pct) v = v ^ 16'($urandom_range(16'hFFFF, 1));
            sdram_data_r = v;
          end
        end
      end
      if (sdram_req) begin
        if (req_num < 16) req_cyc_log[req_num] = cyc;
        if (req_num < 8 && !sdram_rh_wl) wr_log[req_num] = sdram_data_w;
        if (req_num != drop_idx) begin
          pend = 1; cnt = $urandom_range(dmax, dmin);
          p_addr = sdram_addr; p_rd = sdram_rh_wl; p_data = sdram_data_w;
        end
        if (spur_en && $urandom_range(1) == 1) sdram_ack = 1'b1;
        req_num++;
      end else if (stray_en && !pend && drop_idx < 0 && $urandom_range(7) == 0) begin
        sdram_ack = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  int last_done_cyc;

  task automatic do_run(input bit mid_starts);
    bit seen;
    for (int i = 0; i < NW; i++) mem[i] = 16'($urandom);
    req_num = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        last_done_cyc = cyc;
        break;
      end
      start = mid_starts && ($urandom_range(15) == 0);
    end
    start = 1'b0;
    if (!seen) check("done_wait_expired", 0, 1);
  endtask

  initial begin : main
    bit hit;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("lit_rst_busy", busy, 0);
    check("lit_rst_led", led, 0);
    check("lit_rst_rh_wl", sdram_rh_wl, 1);
    reset = 1'b0;

    // start pulse while still counting the power-up wait
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (6) @(negedge clk);
    check("lit_init_start_ignored", req_num, 0);

    // clean run, ack 3 cycles after req
    do_run(0);
    check("lit_run1_pass", pass, 1);
    check("lit_run1_led", led, 8'h55);
    check("lit_run1_err", err_cnt, 0);
    check("lit_run1_reqs", req_num, 8);
    check("lit_wr0", wr_log[0], 16'hF055);
    check("lit_wr1", wr_log[1], 16'hF054);
    check("lit_wr2", wr_log[2], 16'hF057);
    check("lit_wr3", wr_log[3], 16'hF056);

    // word 2 reads back as zero
    corrupt_addr = 2;
    do_run(0);
    corrupt_addr = -1;
    check("lit_run2_err", err_cnt, 1);
    check("lit_run2_first", first_err_addr, 2);
    check("lit_run2_pass", pass, 0);
    check("lit_run2_led", led, 8'hAA);

    // second write never acked
    drop_idx = 1;
    do_run(0);
    check("lit_tmo_latency", last_done_cyc - req_cyc_log[1], TMO);
    check("lit_tmo_flag", timeout, 1);
    check("lit_tmo_pass", pass, 0);
    check("lit_tmo_led", led, 8'hAA);
    repeat (5) @(negedge clk);
    check("lit_tmo_no_more_req", req_num, 2);
    drop_idx = -1;

    // start pulses during the run
    dmin = 1; dmax = 4;
    do_run(1);
    check("lit_midstart_pass", pass, 1);
    check("lit_midstart_reqs", req_num, 8);

    // acks in the request cycle must be ignored
    spur_en = 1;
    do_run(0);
    check("lit_spur_pass", pass, 1);
    spur_en = 0;

    // reset while a read is outstanding
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    hit = 0;
    for (int i = 0; i < 500; i++) begin
      if (m_waiting && m_op >= NW) begin hit = 1; break; end
      @(negedge clk);
    end
    check("rd_wait_reached", hit, 1);
    #1 reset = 1'b1;
    #1;
    check("lit_mid_rst_req", sdram_req, 0);
    check("lit_mid_rst_busy", busy, 0);
    check("lit_mid_rst_led", led, 0);
    check("lit_mid_rst_addr", sdram_addr, 0);
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    req_num = 0;
    repeat (IW + 2) @(negedge clk);
    check("lit_post_rst_no_req", req_num, 0);
    do_run(0);
    check("lit_post_rst_pass", pass, 1);
    check("lit_post_rst_err", err_cnt, 0);

    // randomized runs
    for (int r = 0; r < 10; r++) begin
      dmin        = $urandom_range(2, 1);
      dmax        = dmin + $urandom_range(3, 0);
      corrupt_pct = ($urandom_range(1) == 1) ? 35 : 0;
      spur_en     = $urandom_range(1);
      stray_en    = $urandom_range(1);
      do_run($urandom_range(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
